dram_cas_control: RTL and testbench
===================================

Name: dram_cas_control

Overview:
- Consumes `nras` from the RAS control stage and drives the remaining 4164-style DRAM strobes for the slot-3 RAM bank: multiplexed address `ma`, `ncas`, `nwe`.
- A clocked sequencer on the master clock times the row-hold, row-to-column switch and CAS assertion after each RAS fall.
- Refresh cycles (`nrfshd` low at RAS fall) are executed RAS-only; `ncas` is never asserted for them.
- Enforces a minimum RAS precharge interval before starting the next access.

Parameters:
- ROW_HOLD, 1: clk cycles from RAS-fall detection to `col_sel` rising (row-address hold); range 1..7.
- CAS_DELAY, 1: clk cycles from `col_sel` rising to `ncas` falling; range 1..7.
- PRECHARGE, 2: minimum clk cycles spent in PRECHARGE after RAS-rise detection; range 1..7.

Ports:
- clk, input, 1: master clock, 21.477 MHz (6x CPU clock); all state changes on the rising edge.
- nreset, input, 1: asynchronous active-low reset.
- nras, input, 1: RAS strobe from the RAS control stage; asynchronous to clk.
- nrfshd, input, 1: CPU refresh indicator, active low; asynchronous.
- nwr, input, 1: CPU write strobe, active low; asynchronous.
- a, input, 16: CPU address bus.
- ma, output, 8: DRAM multiplexed address; a[7:0] when `col_sel`=0, a[15:8] when `col_sel`=1. Combinational mux of the registered `col_sel`.
- col_sel, output, 1: registered; 1 while the column address is driven.
- ncas, output, 1: registered CAS strobe, active low.
- nwe, output, 1: registered DRAM write enable, active low.
- busy, output, 1: registered; 1 in any state other than IDLE.

Behaviour:
- Reset (async, `nreset`=0):
  - state=IDLE, all synchronizer flops=1, pending=0, counter=0.
  - `col_sel`=0, `ncas`=1, `nwe`=1, `busy`=0.
- Synchronization:
  - `nras`, `nrfshd` and `nwr` each pass through a 2-flop synchronizer; both flops reset to 1.
  - RAS-fall event: synced `nras`=0 and its previous-cycle value=1. RAS-rise event is the inverse.
  - Edge E = the rising clk edge at which the state register reacts to a RAS-fall event. E is the 3rd rising edge after raw `nras` falls with setup met.
- States: IDLE, ROW, COL, CAS, REFRESH, PRECHARGE.
- IDLE:
  - On RAS fall: go to REFRESH if synced `nrfshd`=0, else go to ROW.
  - Transition taken at E; load counter=ROW_HOLD-1.
- ROW:
  - Counter decrements each cycle; at 0 go to COL.
  - `col_sel`=1 from edge E+ROW_HOLD; load counter=CAS_DELAY-1.
- COL:
  - At counter 0 go to CAS.
  - `ncas`=0 from edge E+ROW_HOLD+CAS_DELAY.
- CAS:
  - Hold `col_sel`=1 and `ncas`=0 until RAS rise.
- REFRESH:
  - `col_sel`=0 and `ncas`=1 throughout; exit on RAS rise.
- RAS rise in ROW, COL, CAS or REFRESH:
  - Aborts the access; on the same edge go to PRECHARGE with `col_sel`=0, `ncas`=1, `nwe`=1.
  - Load counter=PRECHARGE-1.
  - A rise in ROW or COL never produces a CAS pulse.
- PRECHARGE:
  - At counter 0 go to IDLE.
  - A RAS fall during PRECHARGE sets `pending`, latching the synced `nrfshd` value; the fall is not dropped.
  - On completion with `pending`=1: go directly to ROW or REFRESH as if the fall occurred at that edge, then clear `pending`.
- `nwe`:
  - Registered as `nwe` = synced `nwr` while state ∈ {COL, CAS}; forced 1 in every other state.
  - A write can therefore start late within the cycle (Z80 T2 write strobe).
- Simultaneous events:
  - RAS fall and RAS rise cannot coexist on one edge (single signal).
  - `nreset` overrides everything.
  - Reset mid-CAS immediately releases `ncas` and `nwe` and clears `pending`.
- `busy`: 1 in every state except IDLE.

Test Plan:
- Read access, defaults: reset released; drive a=16'hA55A, `nrfshd`=1, `nwr`=1; drop `nras`. Required: `ma`=8'h5A until E+1; `col_sel`=1 and `ma`=8'hA5 from E+1; `ncas`=0 from E+2; `nwe` stays 1. Raise `nras`: `ncas`=1 and `col_sel`=0 by the 3rd edge; `busy`=0 two cycles later.
- Write access: as the read case, but drive `nwr`=0 one CPU half-cycle after `nras` falls. Required: `nwe`=0 while `ncas`=0; `nwe`=1 on the same edge `ncas` rises.
- Refresh: `nrfshd`=0, then drop `nras` for 4 CPU half-cycles. Required: `busy`=1, `ncas` stays 1, `col_sel` stays 0, `ma`=a[7:0] throughout; then PRECHARGE for 2 cycles, then IDLE.
- Aborted access: with ROW_HOLD=3, pulse `nras` low for exactly 3 clk. Required: `ncas` never 0; `col_sel` may reach 1 at most briefly; FSM ends in IDLE.
- Back-to-back: drop `nras` again 1 clk after RAS-rise detection. Required: `pending` set; ROW entered only after PRECHARGE completes (2 cycles); `ncas`=0 at that edge+2.
- Reset mid-CAS: assert `nreset` while `ncas`=0. Required: `ncas`=1, `nwe`=1, `col_sel`=0, `busy`=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/dram_cas_control.sv
// Sequences row hold, column switch and CAS for the slot-3 DRAM bank after each RAS fall; RAS-only refresh.
// Latency: ncas falls ROW_HOLD+CAS_DELAY clk after the synchronized RAS fall; inputs cross 2 sync flops plus 1 edge detector flop.
// Backpressure: none; a RAS fall during precharge is held pending and started as soon as precharge ends.
module dram_cas_control #(
    parameter int ROW_HOLD  = 1,
    parameter int CAS_DELAY = 1,
    parameter int PRECHARGE = 2
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        nras,
    input  logic        nrfshd,
    input  logic        nwr,
    input  logic [15:0] a,
    output logic [7:0]  ma,
    output logic        col_sel,
    output logic        ncas,
    output logic        nwe,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, ROW, COL, CAS, REFRESH, PRE
    } state_t;

    localparam logic [2:0] ROW_LOAD = 3'(ROW_HOLD - 1);
    localparam logic [2:0] CAS_LOAD = 3'(CAS_DELAY - 1);
    localparam logic [2:0] PRE_LOAD = 3'(PRECHARGE - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       pending;
    logic       pend_rf;

    logic ras_s1, ras_s2, ras_d;
    logic rf_s1, rf_s2;
    logic wr_s1, wr_s2;

    logic ras_fall;
    logic ras_rise;

    assign ras_fall = !ras_s2 && ras_d;
    assign ras_rise = ras_s2 && !ras_d;
    assign ma       = col_sel ? a[15:8] : a[7:0];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ras_s1 <= 1'b1;
            ras_s2 <= 1'b1;
            ras_d  <= 1'b1;
            rf_s1  <= 1'b1;
            rf_s2  <= 1'b1;
            wr_s1  <= 1'b1;
            wr_s2  <= 1'b1;
        end else begin
            ras_s1 <= nras;
            ras_s2 <= ras_s1;
            ras_d  <= ras_s2;
            rf_s1  <= nrfshd;
            rf_s2  <= rf_s1;
            wr_s1  <= nwr;
            wr_s2  <= wr_s1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            pending <= 1'b0;
            pend_rf <= 1'b1;
            col_sel <= 1'b0;
            ncas    <= 1'b1;
            nwe     <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ras_fall) begin
                        state <= rf_s2 ? ROW : REFRESH;
                        cnt   <= ROW_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ROW: begin
                    if (ras_rise) begin
                        state   <= PRE;
                        cnt     <= PRE_LOAD;
                        col_sel <= 1'b0;
                        ncas    <= 1'b1;
                        nwe     <= 1'b1;
                    end else if (cnt == 3'd0) begin
                        state   <= COL;
                        cnt     <= CAS_LOAD;
                        col_sel <= 1'b1;
                        nwe     <= wr_s2;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                COL: begin
                    if (ras_rise) begin
                        state   <= PRE;
                        cnt     <= PRE_LOAD;
                        col_sel <= 1'b0;
                        ncas    <= 1'b1;
                        nwe     <= 1'b1;
                    end else begin
                        nwe <= wr_s2;
                        if (cnt == 3'd0) begin
                            state <= CAS;
                            ncas  <= 1'b0;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                end
                CAS: begin
                    if (ras_rise) begin
                        state   <= PRE;
                        cnt     <= PRE_LOAD;
                        col_sel <= 1'b0;
                        ncas    <= 1'b1;
                        nwe     <= 1'b1;
                    end else begin
                        nwe <= wr_s2;
                    end
                end
                REFRESH: begin
                    if (ras_rise) begin
                        state <= PRE;
                        cnt   <= PRE_LOAD;
                    end
                end
                PRE: begin
                    if (cnt == 3'd0) begin
                        // A fall seen while precharging (or on this very edge) starts straight away
                        if (pending || ras_fall) begin
                            state   <= (pending ? pend_rf : rf_s2) ? ROW : REFRESH;
                            cnt     <= ROW_LOAD;
                            pending <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                        if (ras_fall) begin
                            pending <= 1'b1;
                            pend_rf <= rf_s2;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    col_sel <= 1'b0;
                    ncas    <= 1'b1;
                    nwe     <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_cas_control.sv
// Directed bench for dram_cas_control: read, write, refresh, abort, back-to-back and reset mid-CAS.
module tb_dram_cas_control;

    logic        clk;
    logic        nreset;
    logic        nras;
    logic        nras3;
    logic        nrfshd;
    logic        nwr;
    logic [15:0] a;
    logic [7:0]  ma, ma3;
    logic        col_sel, ncas, nwe, busy;
    logic        col_sel3, ncas3, nwe3, busy3;

    int n_checks = 0;
    int n_errors = 0;

    dram_cas_control u_dut (
        .clk(clk), .nreset(nreset), .nras(nras), .nrfshd(nrfshd), .nwr(nwr), .a(a),
        .ma(ma), .col_sel(col_sel), .ncas(ncas), .nwe(nwe), .busy(busy)
    );

    dram_cas_control #(.ROW_HOLD(3)) u_dut3 (
        .clk(clk), .nreset(nreset), .nras(nras3), .nrfshd(nrfshd), .nwr(nwr), .a(a),
        .ma(ma3), .col_sel(col_sel3), .ncas(ncas3), .nwe(nwe3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // advance one clk and sample 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic saw_col, saw_cas;

    initial begin
        nreset = 1'b0;
        nras   = 1'b1;
        nras3  = 1'b1;
        nrfshd = 1'b1;
        nwr    = 1'b1;
        a      = 16'hA55A;
        #12;
        check("rst_ncas", 16'(ncas), 16'd1);
        check("rst_nwe", 16'(nwe), 16'd1);
        check("rst_col_sel", 16'(col_sel), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_ma", 16'(ma), 16'h5A);
        nreset = 1'b1;
        ticks(3);

        // ---- read access ----
        nras = 1'b0;
        ticks(2);
        check("rd_busy_pre_E", 16'(busy), 16'd0);
        tick();                                   // E
        check("rd_busy_E", 16'(busy), 16'd1);
        check("rd_col_E", 16'(col_sel), 16'd0);
        check("rd_ma_row", 16'(ma), 16'h5A);
        tick();                                   // E+1
        check("rd_col_E1", 16'(col_sel), 16'd1);
        check("rd_ma_col", 16'(ma), 16'hA5);
        check("rd_ncas_E1", 16'(ncas), 16'd1);
        tick();                                   // E+2
        check("rd_ncas_E2", 16'(ncas), 16'd0);
        check("rd_nwe", 16'(nwe), 16'd1);
        nras = 1'b1;
        ticks(2);
        check("rd_ncas_hold", 16'(ncas), 16'd0);
        tick();
        check("rd_ncas_rise", 16'(ncas), 16'd1);
        check("rd_col_rise", 16'(col_sel), 16'd0);
        check("rd_busy_pre", 16'(busy), 16'd1);
        tick();
        check("rd_busy_pre2", 16'(busy), 16'd1);
        tick();
        check("rd_busy_idle", 16'(busy), 16'd0);
        ticks(3);

        // ---- write access ----
        nras = 1'b0;
        ticks(3);                                 // E
        nwr = 1'b0;
        tick();                                   // E+1
        check("wr_col", 16'(col_sel), 16'd1);
        tick();                                   // E+2
        check("wr_ncas", 16'(ncas), 16'd0);
        check("wr_nwe_late", 16'(nwe), 16'd1);
        tick();                                   // E+3
        check("wr_nwe_low", 16'(nwe), 16'd0);
        check("wr_ncas_low", 16'(ncas), 16'd0);
        nras = 1'b1;
        ticks(2);
        check("wr_nwe_hold", 16'(nwe), 16'd0);
        tick();
        check("wr_ncas_rise", 16'(ncas), 16'd1);
        check("wr_nwe_rise", 16'(nwe), 16'd1);
        nwr = 1'b1;
        ticks(4);
        check("wr_idle", 16'(busy), 16'd0);

        // ---- refresh ----
        a      = 16'h3CC3;
        nrfshd = 1'b0;
        tick();
        nras = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("rf_ncas", 16'(ncas), 16'd1);
            check("rf_col", 16'(col_sel), 16'd0);
            check("rf_ma", 16'(ma), 16'hC3);
            if (i >= 3) check("rf_busy", 16'(busy), 16'd1);
        end
        nras = 1'b1;
        ticks(4);
        check("rf_busy_pre", 16'(busy), 16'd1);
        check("rf_ncas_pre", 16'(ncas), 16'd1);
        tick();
        check("rf_busy_idle", 16'(busy), 16'd0);
        nrfshd = 1'b1;
        a      = 16'hA55A;
        ticks(3);

        // ---- aborted access, ROW_HOLD=3 instance ----
        saw_col = 1'b0;
        saw_cas = 1'b0;
        nras3 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) nras3 = 1'b1;
            @(posedge clk);
            #1;
            if (col_sel3) saw_col = 1'b1;
            if (!ncas3) saw_cas = 1'b1;
            if (i == 3) check("ab_busy", 16'(busy3), 16'd1);
        end
        check("ab_no_cas", 16'(saw_cas), 16'd0);
        check("ab_no_col", 16'(saw_col), 16'd0);
        check("ab_idle", 16'(busy3), 16'd0);
        check("ab_main_idle", 16'(busy), 16'd0);

        // ---- back-to-back with pending fall ----
        nras = 1'b0;
        ticks(3);                                 // E
        ticks(2);                                 // CAS
        check("bb_ncas_first", 16'(ncas), 16'd0);
        nras = 1'b1;
        tick();
        nras = 1'b0;
        ticks(2);                                 // R: rise detected
        check("bb_ncas_rise", 16'(ncas), 16'd1);
        tick();                                   // R+1: fall lands in precharge
        check("bb_pending", 16'(u_dut.pending), 16'd1);
        check("bb_busy", 16'(busy), 16'd1);
        tick();                                   // R+2: precharge done, ROW
        check("bb_col_row", 16'(col_sel), 16'd0);
        check("bb_busy2", 16'(busy), 16'd1);
        check("bb_pending_clr", 16'(u_dut.pending), 16'd0);
        tick();                                   // R+3
        check("bb_col", 16'(col_sel), 16'd1);
        check("bb_ncas_col", 16'(ncas), 16'd1);
        tick();                                   // R+4
        check("bb_ncas", 16'(ncas), 16'd0);

        // ---- reset mid-CAS ----
        nwr = 1'b0;
        ticks(3);
        check("rs_nwe_pre", 16'(nwe), 16'd0);
        #1;
        nreset = 1'b0;
        #1;
        check("rs_ncas", 16'(ncas), 16'd1);
        check("rs_nwe", 16'(nwe), 16'd1);
        check("rs_col", 16'(col_sel), 16'd0);
        check("rs_busy", 16'(busy), 16'd0);
        nras = 1'b1;
        nwr  = 1'b1;
        #3;
        nreset = 1'b1;
        ticks(4);
        check("rs_idle", 16'(busy), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
